// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port of the memory-access stage.
// The master side is the pipeline stage; the slave side is the data memory.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, be, addr, wdata, input rdata, ack);
    modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: holds the EX/MEM bundle, runs the data-memory
// req/ack transaction, places store lanes and extends load data.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_flush,
    input  logic              Branch_in,
    input  logic              zero_in,
    input  logic              overflow_in,
    input  logic              MemtoReg_in,
    input  logic [1:0]        MemWrite_in,
    input  logic [2:0]        MemRead_in,
    input  logic              RegWrite_in,
    input  logic [4:0]        rd_in,
    input  logic [DATA_W-1:0] Aluout_in,
    input  logic [DATA_W-1:0] busB_in,
    input  logic              mtc0_in,
    input  logic              mfc0_in,
    mem_access_if.master      dm,
    output logic              stall,
    output logic              pc_src,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              mtc0_out,
    output logic              mfc0_out,
    output logic [4:0]        rd_out,
    output logic [DATA_W-1:0] Aluout_out,
    output logic [DATA_W-1:0] memdata_out,
    output logic              adel,
    output logic              ades,
    output logic              ov_exc
);
    typedef struct packed {
        logic              branch;
        logic              zero;
        logic              overflow;
        logic              memtoreg;
        logic [1:0]        memwrite;
        logic [2:0]        memread;
        logic              regwrite;
        logic [4:0]        rd;
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] busb;
        logic              mtc0;
        logic              mfc0;
    } bundle_t;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    // Access size code: 01 word, 10 half, 11 byte, 00 none; a store wins over a load.
    function automatic logic [1:0] access_size(input logic [1:0] mw, input logic [2:0] mr);
        logic [1:0] sz;
        if (mw != 2'b00) begin
            sz = mw;
        end else begin
            case (mr)
                3'd1:       sz = 2'b01;
                3'd2, 3'd3: sz = 2'b10;
                3'd4, 3'd5: sz = 2'b11;
                default:    sz = 2'b00;
            endcase
        end
        return sz;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] mw, input logic [1:0] a);
        logic [3:0] be;
        case (mw)
            2'b01:   be = 4'b1111;
            2'b10:   be = a[1] ? 4'b1100 : 4'b0011;
            2'b11:   be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] mw, input logic [31:0] d);
        logic [31:0] w;
        case (mw)
            2'b10:   w = {2{d[15:0]}};
            2'b11:   w = {4{d[7:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] mr, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (mr)
            3'd1:    v = d;
            3'd2:    v = {{16{h[15]}}, h};
            3'd3:    v = {16'h0000, h};
            3'd4:    v = {{24{b[7]}}, b};
            3'd5:    v = {24'h000000, b};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    bundle_t           stage_r;
    bundle_t           in_s;
    state_t            state_r, next_s;
    logic [DATA_W-1:0] memdata_r;
    logic [1:0]        size_s;
    logic              is_store_s, is_load_s, misal_s, mem_op_s;
    logic              req_s, stall_s, capture_s;

    assign in_s = '{branch: Branch_in, zero: zero_in, overflow: overflow_in,
                    memtoreg: MemtoReg_in, memwrite: MemWrite_in, memread: MemRead_in,
                    regwrite: RegWrite_in, rd: rd_in, aluout: Aluout_in, busb: busB_in,
                    mtc0: mtc0_in, mfc0: mfc0_in};

    assign size_s     = access_size(stage_r.memwrite, stage_r.memread);
    assign is_store_s = (stage_r.memwrite != 2'b00);
    assign is_load_s  = !is_store_s && (size_s != 2'b00);
    assign misal_s    = ((size_s == 2'b01) && (stage_r.aluout[1:0] != 2'b00)) ||
                        ((size_s == 2'b10) && stage_r.aluout[0]);
    assign mem_op_s   = (is_store_s || is_load_s) && !misal_s;

    // Stage register: advances whenever the stage is not stalled; a flush inserts a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r <= '0;
        end else if (!stall_s) begin
            stage_r <= mem_flush ? bundle_t'('0) : in_s;
        end else begin
            stage_r <= stage_r;
        end
    end

    // Transaction state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Load data capture at the acknowledging edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memdata_r <= '0;
        end else if (capture_s) begin
            memdata_r <= load_extract(stage_r.memread, stage_r.aluout[1:0], dm.rdata);
        end else begin
            memdata_r <= memdata_r;
        end
    end

    // Next-state and request/stall decode; DONE keeps the op one more cycle without a request.
    always_comb begin
        next_s    = state_r;
        req_s     = 1'b0;
        stall_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_op_s) begin
                    req_s   = 1'b1;
                    stall_s = 1'b1;
                    if (dm.ack) begin
                        next_s    = S_DONE;
                        capture_s = is_load_s;
                    end else begin
                        next_s = S_WAIT;
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (dm.ack) begin
                    next_s    = S_DONE;
                    capture_s = is_load_s;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    assign dm.req   = req_s;
    assign dm.we    = req_s && is_store_s;
    assign dm.be    = (req_s && is_store_s) ? store_be(stage_r.memwrite, stage_r.aluout[1:0]) : 4'b0000;
    assign dm.addr  = {stage_r.aluout[ADDR_W-1:2], 2'b00};
    assign dm.wdata = store_wdata(stage_r.memwrite, stage_r.busb);

    // Write-back only commits once the access has finished and raised no exception.
    assign stall        = stall_s;
    assign pc_src       = stage_r.branch && stage_r.zero;
    assign RegWrite_out = stage_r.regwrite && !misal_s && !stage_r.overflow && !stall_s;
    assign MemtoReg_out = stage_r.memtoreg;
    assign mtc0_out     = stage_r.mtc0;
    assign mfc0_out     = stage_r.mfc0;
    assign rd_out       = stage_r.rd;
    assign Aluout_out   = stage_r.aluout;
    assign memdata_out  = memdata_r;
    assign adel         = is_load_s && misal_s;
    assign ades         = is_store_s && misal_s;
    assign ov_exc       = stage_r.overflow;
endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access against a transaction-level reference model,
// with directed scenarios pinning reset, lane placement, extension and exceptions.
module tb_mem_access;
    typedef struct packed {
        logic        branch;
        logic        zero;
        logic        overflow;
        logic        memtoreg;
        logic [1:0]  mw;
        logic [2:0]  mr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] busb;
        logic        mtc0;
        logic        mfc0;
    } bund_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    bund_t       in_b = '0;
    logic        stall, pc_src, RegWrite_out, MemtoReg_out, mtc0_out, mfc0_out;
    logic [4:0]  rd_out;
    logic [31:0] Aluout_out, memdata_out;
    logic        adel, ades, ov_exc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the bundle in the stage, whether its access finished, last load value.
    bund_t       h = '0;
    logic        done_m = 1'b0;
    logic [31:0] mem_m = 32'h0;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) dmif ();

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .mem_flush(flush),
        .Branch_in(in_b.branch), .zero_in(in_b.zero), .overflow_in(in_b.overflow),
        .MemtoReg_in(in_b.memtoreg), .MemWrite_in(in_b.mw), .MemRead_in(in_b.mr),
        .RegWrite_in(in_b.rw), .rd_in(in_b.rd), .Aluout_in(in_b.alu), .busB_in(in_b.busb),
        .mtc0_in(in_b.mtc0), .mfc0_in(in_b.mfc0), .dm(dmif),
        .stall(stall), .pc_src(pc_src), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .mtc0_out(mtc0_out), .mfc0_out(mfc0_out),
        .rd_out(rd_out), .Aluout_out(Aluout_out), .memdata_out(memdata_out),
        .adel(adel), .ades(ades), .ov_exc(ov_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes touched by the access (0 = no memory op); a store takes priority over a load.
    function automatic int acc_bytes(bund_t b);
        if (b.mw == 2'd1) return 4;
        if (b.mw == 2'd2) return 2;
        if (b.mw == 2'd3) return 1;
        if (b.mr == 3'd1) return 4;
        if (b.mr == 3'd2 || b.mr == 3'd3) return 2;
        if (b.mr == 3'd4 || b.mr == 3'd5) return 1;
        return 0;
    endfunction

    function automatic logic aligned(bund_t b);
        int s = acc_bytes(b);
        return (s == 0) || ((int'(b.alu[1:0]) % s) == 0);
    endfunction

    function automatic logic busy();
        return (acc_bytes(h) != 0) && aligned(h) && !done_m;
    endfunction

    function automatic logic [31:0] extract(bund_t b, logic [31:0] d);
        int          s = acc_bytes(b);
        logic [31:0] v = d >> (8 * int'(b.alu[1:0]));
        if (s == 1) v = (b.mr == 3'd4) ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
        else if (s == 2) v = (b.mr == 3'd2) ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
        return v;
    endfunction

    task automatic model_reset();
        h = '0;
        done_m = 1'b0;
        mem_m = 32'h0;
    endtask

    // Advance the model over one rising edge with the inputs currently applied.
    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else if (busy()) begin
            if (dmif.ack) begin
                done_m = 1'b1;
                if (h.mw == 2'd0) mem_m = extract(h, dmif.rdata);
            end
        end else begin
            h = flush ? bund_t'('0) : in_b;
            done_m = 1'b0;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        int          s, off, ssz;
        logic        st, store;
        logic [3:0]  be;
        logic [31:0] wd;
        s = acc_bytes(h);
        off = int'(h.alu[1:0]);
        st = busy();
        store = (h.mw != 2'd0);
        ssz = (h.mw == 2'd2) ? 2 : (h.mw == 2'd3) ? 1 : 4;
        be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (st && store && i >= off && i < off + s) be[i] = 1'b1;
            wd[8*i +: 8] = h.busb[8*(i % ssz) +: 8];
        end
        chk("stall", {31'h0, stall}, {31'h0, st});
        chk("dm_req", {31'h0, dmif.req}, {31'h0, st});
        chk("dm_we", {31'h0, dmif.we}, {31'h0, st && store});
        chk("dm_be", {28'h0, dmif.be}, {28'h0, be});
        chk("dm_addr", dmif.addr, {h.alu[31:2], 2'b00});
        chk("dm_wdata", dmif.wdata, wd);
        chk("pc_src", {31'h0, pc_src}, {31'h0, h.branch && h.zero});
        chk("RegWrite_out", {31'h0, RegWrite_out},
            {31'h0, h.rw && aligned(h) && !h.overflow && !st});
        chk("wb_flags", {28'h0, MemtoReg_out, mtc0_out, mfc0_out, ov_exc},
            {28'h0, h.memtoreg, h.mtc0, h.mfc0, h.overflow});
        chk("rd_out", {27'h0, rd_out}, {27'h0, h.rd});
        chk("Aluout_out", Aluout_out, h.alu);
        chk("memdata_out", memdata_out, mem_m);
        chk("adel", {31'h0, adel}, {31'h0, s != 0 && !aligned(h) && !store});
        chk("ades", {31'h0, ades}, {31'h0, s != 0 && !aligned(h) && store});
    end

    // One clock: apply inputs just after an edge, let the edge happen, update the model.
    task automatic step(input bund_t b, input logic fl, input logic ack, input logic [31:0] rdata);
        in_b = b;
        flush = fl;
        dmif.ack = ack;
        dmif.rdata = rdata;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic bund_t mk(logic [1:0] mw, logic [2:0] mr, logic rw, logic [4:0] rd,
                                 logic [31:0] alu, logic [31:0] busb);
        bund_t b = '0;
        b.mw = mw; b.mr = mr; b.rw = rw; b.rd = rd; b.alu = alu; b.busb = busb;
        return b;
    endfunction

    function automatic bund_t rand_bund();
        bund_t b = '0;
        b.branch = 1'($urandom_range(0, 1));
        b.zero = 1'($urandom_range(0, 1));
        b.overflow = ($urandom_range(0, 7) == 0);
        b.memtoreg = 1'($urandom_range(0, 1));
        b.mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        b.mr = 3'($urandom_range(0, 7));
        b.rw = 1'($urandom_range(0, 1));
        b.rd = 5'($urandom);
        b.alu = $urandom;
        if ($urandom_range(0, 1) == 1) b.alu[1:0] = 2'b00;
        b.busb = $urandom;
        b.mtc0 = 1'($urandom_range(0, 1));
        b.mfc0 = 1'($urandom_range(0, 1));
        return b;
    endfunction

    initial begin : stim
        bund_t nop, b;
        int    cnt;
        nop = '0;
        dmif.ack = 1'b0;
        dmif.rdata = 32'h0;
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_memdata", memdata_out, 32'h0);
        reset = 1'b1;

        // lb / lbu at 0x1003 with same-cycle ack
        b = mk(2'd0, 3'd4, 1'b1, 5'd3, 32'h0000_1003, 32'h0);
        step(b, 1'b0, 1'b0, 32'h0);
        chk("lb_stall_on", {31'h0, stall}, 32'h1);
        chk("lb_req_on", {31'h0, dmif.req}, 32'h1);
        step(nop, 1'b0, 1'b1, 32'h80AA_5511);
        chk("lb_stall_off", {31'h0, stall}, 32'h0);
        chk("lb_memdata", memdata_out, 32'hFFFF_FF80);
        chk("lb_regwrite", {31'h0, RegWrite_out}, 32'h1);
        step(nop, 1'b0, 1'b0, 32'h0);
        b.mr = 3'd5;
        step(b, 1'b0, 1'b0, 32'h0);
        step(nop, 1'b0, 1'b1, 32'h80AA_5511);
        chk("lbu_memdata", memdata_out, 32'h0000_0080);
        step(nop, 1'b0, 1'b0, 32'h0);

        // sh at 0x2002, ack after three wait cycles
        b = mk(2'd2, 3'd0, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_BEEF);
        step(b, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall) cnt++;
            chk("sh_be", {28'h0, dmif.be}, 32'h0000_000C);
            chk("sh_wdata", dmif.wdata, 32'hBEEF_BEEF);
            chk("sh_we", {31'h0, dmif.we}, 32'h1);
            chk("sh_addr", dmif.addr, 32'h0000_2000);
            step(nop, 1'b0, (i == 3), 32'h0);
        end
        chk("sh_stall_cycles", cnt, 32'd4);
        chk("sh_done_stall", {31'h0, stall}, 32'h0);
        step(nop, 1'b0, 1'b0, 32'h0);

        // misaligned lw / sw
        step(mk(2'd0, 3'd1, 1'b1, 5'd7, 32'h0000_3001, 32'h0), 1'b0, 1'b0, 32'h0);
        chk("lw_adel", {31'h0, adel}, 32'h1);
        chk("lw_noreq", {31'h0, dmif.req}, 32'h0);
        chk("lw_noreg", {31'h0, RegWrite_out}, 32'h0);
        chk("lw_nostall", {31'h0, stall}, 32'h0);
        step(mk(2'd1, 3'd0, 1'b0, 5'd0, 32'h0000_3002, 32'h1234_5678), 1'b0, 1'b0, 32'h0);
        chk("sw_ades", {31'h0, ades}, 32'h1);

        // branch, then a flushed branch
        b = mk(2'd0, 3'd0, 1'b1, 5'd9, 32'h0, 32'h0);
        b.branch = 1'b1;
        b.zero = 1'b1;
        step(b, 1'b0, 1'b0, 32'h0);
        chk("br_pc_src", {31'h0, pc_src}, 32'h1);
        chk("br_nostall", {31'h0, stall}, 32'h0);
        step(b, 1'b1, 1'b0, 32'h0);
        chk("flush_pc_src", {31'h0, pc_src}, 32'h0);
        chk("flush_regwrite", {31'h0, RegWrite_out}, 32'h0);

        // overflow then a clean add
        b = mk(2'd0, 3'd0, 1'b1, 5'd5, 32'h7, 32'h0);
        b.overflow = 1'b1;
        step(b, 1'b0, 1'b0, 32'h0);
        chk("ov_exc", {31'h0, ov_exc}, 32'h1);
        chk("ov_regwrite", {31'h0, RegWrite_out}, 32'h0);
        step(mk(2'd0, 3'd0, 1'b1, 5'd6, 32'h8, 32'h0), 1'b0, 1'b0, 32'h0);
        chk("add_regwrite", {31'h0, RegWrite_out}, 32'h1);
        chk("add_ov", {31'h0, ov_exc}, 32'h0);
        chk("add_rd", {27'h0, rd_out}, 32'd6);

        // reset in the middle of a waiting store
        step(mk(2'd2, 3'd0, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_BEEF), 1'b0, 1'b0, 32'h0);
        step(nop, 1'b0, 1'b0, 32'h0);
        chk("wait_req", {31'h0, dmif.req}, 32'h1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_req", {31'h0, dmif.req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_outs", {20'h0, pc_src, RegWrite_out, MemtoReg_out, mtc0_out, mfc0_out, adel,
                         ades, ov_exc, dmif.we, dmif.be} | {27'h0, rd_out} | Aluout_out |
                         memdata_out | dmif.addr | dmif.wdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(nop, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("late_ack_stall", {31'h0, stall}, 32'h0);
        chk("late_ack_memdata", memdata_out, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(rand_bund(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0), $urandom);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the five-stage MIPS pipeline. It is the consumer of the execute stage's output bundle.
- Registers the EX/MEM bundle and drives a req/ack data-memory port. It generates store byte-enables and sign/zero-extends load data per access size.
- Stalls upstream while a memory transaction is outstanding. Delivers the write-back bundle and branch-taken decision to later stages.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_flush  in  1  replace the next captured bundle with a bubble.
- Branch_in  in  1  branch instruction flag from execute.
- zero_in  in  1  ALU zero flag.
- overflow_in  in  1  ALU overflow flag.
- MemtoReg_in  in  1  write-back selects memory data.
- MemWrite_in  in  2  store size: 00 none, 01 word, 10 half, 11 byte.
- MemRead_in  in  3  load type: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 treated as none.
- RegWrite_in  in  1  register write enable.
- rd_in  in  5  destination register.
- Aluout_in  in  32  effective address / ALU result.
- busB_in  in  32  store data.
- mtc0_in, mfc0_in  in  1 each  CP0 move flags.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = store.
- dm_be  out  4  byte enables; bit i = byte lane i, little-endian.
- dm_addr  out  32  word address: {addr[31:2],2'b00}.
- dm_wdata  out  32  store data replicated into the lanes.
- dm_rdata  in  32  load data; valid when dm_ack=1.
- dm_ack  in  1  transaction complete.
- stall  out  1  freeze execute stage and earlier.
- pc_src  out  1  Branch & zero of the held bundle.
- RegWrite_out, MemtoReg_out, mtc0_out, mfc0_out  out  1 each  to write-back.
- rd_out  out  5  to write-back.
- Aluout_out, memdata_out  out  32  to write-back.
- adel, ades, ov_exc  out  1 each  load-misalign, store-misalign and overflow exceptions.

Behaviour:
- Stage register
  - Loads all *_in signals on a rising edge when stall=0.
  - If mem_flush=1 at that edge, it loads a bubble instead: all control fields 0, data fields 0.
  - Holds its contents while stall=1. mem_flush is ignored while stall=1.
- Reset (reset=0, asynchronous)
  - Stage register is cleared to a bubble, memdata register to 0, FSM to IDLE.
  - Consequently every output is 0, including stall, dm_req and pc_src.
- Misalignment check (on the held bundle)
  - Word access requires addr[1:0]=00; half access requires addr[0]=0; byte access is always aligned.
  - Misaligned load: adel=1. Misaligned store: ades=1.
  - A misaligned access issues no dm_req, forces RegWrite_out=0, and does not stall.
- Overflow: ov_exc = overflow held in the stage register; when ov_exc=1, RegWrite_out=0.
- FSM, states IDLE, WAIT, DONE
  - IDLE with a non-memory or misaligned op: stall=0, dm_req=0; the op leaves the stage after 1 cycle.
  - IDLE with an aligned memory op: dm_req=1, stall=1.
    - If dm_ack=1 in the same cycle: capture load data, go to DONE.
    - Otherwise go to WAIT.
  - WAIT: dm_req=1, stall=1, address/data/be held stable; on dm_ack=1 capture data and go to DONE.
  - DONE: dm_req=0, stall=0, write-back outputs valid; the stage register loads the next bundle; go to IDLE.
  - Minimum residency for a memory op is 2 cycles.
- Store lanes
  - Word: be=1111, wdata=busB.
  - Half: be=0011 if addr[1]=0, else 1100; wdata={2{busB[15:0]}}.
  - Byte: be=0001<<addr[1:0]; wdata={4{busB[7:0]}}.
- Load extraction from dm_rdata at ack
  - Select the byte/half by addr[1:0]/addr[1].
  - Sign-extend for lb/lh; zero-extend for lbu/lhu; full word for lw.
  - memdata_out holds the captured value until the next capture.
- dm_we=1 only for stores. A bundle with both MemRead and MemWrite nonzero is treated as a store.
- pc_src = Branch & zero of the held bundle. Branch never stalls.
- Write-back pass-through: Aluout_out, rd_out, MemtoReg_out, mtc0_out and mfc0_out come straight from the stage register.
- Reset asserted during WAIT aborts the transaction: dm_req drops immediately; a late dm_ack is ignored once in IDLE with a bubble.

Test Plan:
- Reset: reset=0 mid-WAIT with dm_req=1 -> dm_req=0, stall=0 and all outputs 0 immediately; FSM in IDLE after release.
- lb, addr=0x1003, dm_rdata=0x80AA5511, ack in the first cycle -> memdata_out=0xFFFFFF80, stall high exactly 1 cycle. Same access as lbu -> 0x00000080.
- sh, addr=0x2002, busB=0x0000BEEF -> dm_be=1100, dm_wdata=0xBEEFBEEF, dm_we=1, dm_addr=0x2000. ack after 3 cycles -> stall high 4 cycles, request fields stable throughout.
- lw at addr=0x3001 -> adel=1, dm_req=0, RegWrite_out=0, stall=0. sw at 0x3002 -> ades=1.
- Branch=1, zero=1, MemRead=0 -> pc_src=1 with no stall. mem_flush=1 at the load edge -> bubble captured, pc_src=0, RegWrite_out=0.
- RegWrite=1, overflow=1, rd=5 -> ov_exc=1, RegWrite_out=0. Next bundle (add, rd=6) -> RegWrite_out=1, ov_exc=0.
